// File: rtl/triangle_edge_rasterizer.sv
// triangle_edge_rasterizer
// Turns the transformed x,y,z,w coordinate stream into wireframe triangles.
// Every COORDS beats form one vertex ({x,y} kept, z/w ignored), vertices queue
// in a small FIFO, and each group of 3 is drawn as three Bresenham edges into
// an 8-bit framebuffer write port.
// Ports:
//   clk, reset  clock; synchronous active-low reset
//   in_coord    signed coordinate beat, qualified by in_valid (no backpressure)
//   fb_we       pixel write request, held while fb_ready is low
//   fb_addr     py*H_RES+px of the pixel being written
//   fb_data     constant pixel value COLOR
//   fb_ready    framebuffer accepts the write this cycle
//   busy        3+ vertices queued or a triangle in progress
//   tri_count   completed triangles (wraps)
//   overflow    sticky: a vertex was dropped on a full FIFO
module triangle_edge_rasterizer #(
  parameter int         M      = 11,
  parameter int         COORDS = 4,
  parameter int         H_RES  = 800,
  parameter int         V_RES  = 600,
  parameter int         FIFO_D = 8,
  parameter logic [7:0] COLOR  = 8'hFF,
  parameter int         AW     = 19
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [M-1:0]  in_coord,
  input  logic          in_valid,
  output logic          fb_we,
  output logic [AW-1:0] fb_addr,
  output logic [7:0]    fb_data,
  input  logic          fb_ready,
  output logic          busy,
  output logic [15:0]   tri_count,
  output logic          overflow
);

  localparam int BW = (COORDS > 1) ? $clog2(COORDS) : 1;
  localparam int PW = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;
  localparam int CW = M + 1;
  localparam int EW = M + 3;
  localparam logic signed [CW-1:0] H_HALF = CW'(H_RES / 2);
  localparam logic signed [CW-1:0] V_HALF = CW'(V_RES / 2);
  localparam logic signed [CW-1:0] H_LIM  = CW'(H_RES);
  localparam logic signed [CW-1:0] V_LIM  = CW'(V_RES);
  localparam logic [AW-1:0]        H_RES_A   = AW'(H_RES);
  localparam logic [PW:0]          FIFO_FULL = (PW+1)'(FIFO_D);
  localparam logic [PW:0]          TRI_MIN   = (PW+1)'(3);

  typedef enum logic [2:0] {IDLE, LOAD, SETUP, DRAW, NEXT} state_t;

  // Vertex assembly
  logic [BW-1:0] beat;
  logic [M-1:0]  x_lat, y_lat, push_y;
  logic          last_beat, push_req;

  assign last_beat = (beat == BW'(COORDS - 1));
  assign push_req  = in_valid && last_beat;
  // With COORDS==2 the y beat is also the push beat, so bypass the latch.
  assign push_y    = (beat == BW'(1)) ? in_coord : y_lat;

  always_ff @(posedge clk) begin
    if (!reset) begin
      beat  <= '0;
      x_lat <= '0;
      y_lat <= '0;
    end else if (in_valid) begin
      beat <= last_beat ? '0 : beat + BW'(1);
      if (beat == '0)     x_lat <= in_coord;
      if (beat == BW'(1)) y_lat <= in_coord;
    end
  end

  // Vertex FIFO; pointers wrap naturally because FIFO_D is a power of 2.
  logic [2*M-1:0] fifo_mem [FIFO_D];
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [PW:0]    fifo_cnt;
  logic           fifo_full, push, pop;
  logic [M-1:0]   head_x, head_y;

  assign fifo_full = (fifo_cnt == FIFO_FULL);
  assign push      = push_req && !fifo_full;
  assign head_x    = fifo_mem[rd_ptr][2*M-1:M];
  assign head_y    = fifo_mem[rd_ptr][M-1:0];

  always_ff @(posedge clk) begin
    if (reset && push) fifo_mem[wr_ptr] <= {x_lat, push_y};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + (PW+1)'(1);
        2'b01:   fifo_cnt <= fifo_cnt - (PW+1)'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
      if (push_req && fifo_full) overflow <= 1'b1;
    end
  end

  // Triangle / edge state
  state_t               state, next_state;
  logic [1:0]           load_idx, edge_idx, edge_nxt;
  logic signed [M-1:0]  vx [3];
  logic signed [M-1:0]  vy [3];
  logic signed [CW-1:0] px, py, end_x, end_y;
  logic signed [EW-1:0] dx, dy, err, err_step;
  logic                 step_x_neg, step_y_neg;

  // Edge setup: screen-space end points, deltas and directions.
  logic signed [CW-1:0] s_px, s_py, s_ex, s_ey;
  logic signed [EW-1:0] s_difx, s_dify, s_adx, s_ady;

  always_comb begin
    edge_nxt = (edge_idx == 2'd2) ? 2'd0 : edge_idx + 2'd1;
    s_px   = {vx[edge_idx][M-1], vx[edge_idx]} + H_HALF;
    s_py   = V_HALF - {vy[edge_idx][M-1], vy[edge_idx]};
    s_ex   = {vx[edge_nxt][M-1], vx[edge_nxt]} + H_HALF;
    s_ey   = V_HALF - {vy[edge_nxt][M-1], vy[edge_nxt]};
    s_difx = {{2{s_ex[CW-1]}}, s_ex} - {{2{s_px[CW-1]}}, s_px};
    s_dify = {{2{s_ey[CW-1]}}, s_ey} - {{2{s_py[CW-1]}}, s_py};
    s_adx  = s_difx[EW-1] ? -s_difx : s_difx;
    s_ady  = s_dify[EW-1] ? -s_dify : s_dify;
  end

  // Bresenham step decision; both axes may step in the same cycle.
  logic signed [EW:0] e2, dx_w, dy_w;
  logic on_screen, at_end, x_step, y_step, step;

  assign e2        = {err, 1'b0};
  assign dx_w      = {dx[EW-1], dx};
  assign dy_w      = {dy[EW-1], dy};
  assign x_step    = (e2 >= dy_w);
  assign y_step    = (e2 <= dx_w);
  assign err_step  = err + (x_step ? dy : '0) + (y_step ? dx : '0);
  assign on_screen = !px[CW-1] && (px < H_LIM) && !py[CW-1] && (py < V_LIM);
  assign at_end    = (px == end_x) && (py == end_y);

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // A stalled on-screen write freezes everything; off-screen pixels never stall.
  always_comb begin
    next_state = state;
    pop        = 1'b0;
    fb_we      = 1'b0;
    step       = 1'b0;
    case (state)
      IDLE:  if (fifo_cnt >= TRI_MIN) next_state = LOAD;
      LOAD: begin
        pop = 1'b1;
        if (load_idx == 2'd2) next_state = SETUP;
      end
      SETUP: next_state = DRAW;
      DRAW: begin
        fb_we = on_screen;
        if (!(on_screen && !fb_ready)) begin
          if (at_end) next_state = NEXT;
          else        step = 1'b1;
        end
      end
      NEXT:    next_state = (edge_idx == 2'd2) ? IDLE : SETUP;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      load_idx   <= '0;
      edge_idx   <= '0;
      px         <= '0;
      py         <= '0;
      end_x      <= '0;
      end_y      <= '0;
      dx         <= '0;
      dy         <= '0;
      err        <= '0;
      step_x_neg <= 1'b0;
      step_y_neg <= 1'b0;
      tri_count  <= '0;
      for (int i = 0; i < 3; i++) begin
        vx[i] <= '0;
        vy[i] <= '0;
      end
    end else begin
      case (state)
        LOAD: begin
          vx[load_idx] <= head_x;
          vy[load_idx] <= head_y;
          load_idx     <= (load_idx == 2'd2) ? 2'd0 : load_idx + 2'd1;
          edge_idx     <= 2'd0;
        end
        SETUP: begin
          px         <= s_px;
          py         <= s_py;
          end_x      <= s_ex;
          end_y      <= s_ey;
          dx         <= s_adx;
          dy         <= -s_ady;
          err        <= s_adx - s_ady;
          step_x_neg <= (s_ex < s_px);
          step_y_neg <= (s_ey < s_py);
        end
        DRAW: begin
          if (step) begin
            err <= err_step;
            if (x_step) px <= step_x_neg ? px - CW'(1) : px + CW'(1);
            if (y_step) py <= step_y_neg ? py - CW'(1) : py + CW'(1);
          end
        end
        NEXT: begin
          edge_idx <= edge_nxt;
          if (edge_idx == 2'd2) tri_count <= tri_count + 16'd1;
        end
        default: ;
      endcase
    end
  end

  assign busy    = (fifo_cnt >= TRI_MIN) || (state != IDLE);
  assign fb_data = COLOR;
  assign fb_addr = (state == DRAW) ? (AW'($unsigned(py)) * H_RES_A + AW'($unsigned(px))) : '0;

endmodule

// File: tb/tb_triangle_edge_rasterizer.sv
// tb_triangle_edge_rasterizer
// Drives whole triangles into triangle_edge_rasterizer and checks every accepted
// framebuffer write against a reference Bresenham model through an address queue.
module tb_triangle_edge_rasterizer;

  logic        clk, reset, in_valid, fb_ready, fb_we, busy, overflow;
  logic [10:0] in_coord;
  logic [18:0] fb_addr;
  logic [7:0]  fb_data;
  logic [15:0] tri_count;

  int   checks = 0;
  int   errors = 0;
  int   write_cnt = 0;
  int   exp_tri = 0;
  int   exp_q[$];
  bit   toggle_mode = 0;
  bit   stall_pending = 0;
  logic [18:0] held_addr;

  typedef struct {
    int x0, y0, x1, y1, x2, y2;
    bit toggle;
    int exp_writes;
  } vec_t;

  vec_t vecs[4];

  triangle_edge_rasterizer #(.FIFO_D(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_coord  (in_coord),
    .in_valid  (in_valid),
    .fb_we     (fb_we),
    .fb_addr   (fb_addr),
    .fb_data   (fb_data),
    .fb_ready  (fb_ready),
    .busy      (busy),
    .tri_count (tri_count),
    .overflow  (overflow)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // Alternating fb_ready for the stall sequence
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (toggle_mode) fb_ready = ~fb_ready;
    end
  end

  // Scoreboard: every accepted write pops one expected address; a stalled
  // write must reappear unchanged on the following cycle.
  always @(negedge clk) begin
    if (reset) begin
      if (fb_we && fb_ready) begin
        write_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_write: got addr %0d, expected no write", fb_addr);
        end else begin
          int exp_addr;
          exp_addr = exp_q.pop_front();
          if (int'(fb_addr) != exp_addr) begin
            errors++;
            $display("[TB] FAIL write_addr: got %0d, expected %0d", fb_addr, exp_addr);
          end
        end
      end
      if (stall_pending) begin
        checks++;
        if (fb_we !== 1'b1 || fb_addr !== held_addr) begin
          errors++;
          $display("[TB] FAIL stall_hold: got we=%0b addr=%0d, expected we=1 addr=%0d",
                   fb_we, fb_addr, held_addr);
        end
      end
      stall_pending = fb_we && !fb_ready;
      held_addr     = fb_addr;
    end else begin
      stall_pending = 0;
    end
  end

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // One vertex = 4 consecutive beats x, y, z, w
  task automatic apply_stimulus(input int x, input int y);
    for (int b = 0; b < 4; b++) begin
      if (b == 0)      in_coord = 11'(x);
      else if (b == 1) in_coord = 11'(y);
      else             in_coord = 11'($urandom_range(0, 2047));
      in_valid = 1;
      @(posedge clk);
      #1;
    end
    in_valid = 0;
  endtask

  // Reference wireframe model: queue every on-screen pixel of the 3 edges
  task automatic model_triangle(input int ax, input int ay, input int bx,
                                input int by, input int cx, input int cy);
    int xs[3];
    int ys[3];
    int x, y, x1, y1, dx, dy, sx, sy, err, e2, guard;
    xs = '{ax, bx, cx};
    ys = '{ay, by, cy};
    for (int e = 0; e < 3; e++) begin
      x  = xs[e] + 400;
      y  = 300 - ys[e];
      x1 = xs[(e + 1) % 3] + 400;
      y1 = 300 - ys[(e + 1) % 3];
      dx = (x1 > x) ? x1 - x : x - x1;
      dy = (y1 > y) ? -(y1 - y) : -(y - y1);
      sx = (x1 >= x) ? 1 : -1;
      sy = (y1 >= y) ? 1 : -1;
      err = dx + dy;
      guard = 0;
      while (1) begin
        if (x >= 0 && x < 800 && y >= 0 && y < 600) exp_q.push_back(y * 800 + x);
        if ((x == x1 && y == y1) || guard > 4000) break;
        e2 = 2 * err;
        if (e2 >= dy) begin err += dy; x += sx; end
        if (e2 <= dx) begin err += dx; y += sy; end
        guard++;
      end
    end
  endtask

  task automatic wait_done(input int target);
    int n;
    n = 0;
    while ((int'(tri_count) != target || busy) && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 2000) begin
      checks++;
      errors++;
      $display("[TB] FAIL done_timeout: got tri_count %0d, expected %0d", tri_count, target);
    end
  endtask

  initial begin
    int lat;
    int ox[3];
    int oy[3];
    reset    = 0;
    in_valid = 0;
    in_coord = '0;
    fb_ready = 1;
    vecs[0] = '{0, 0, 3, 0, 0, 3, 1'b0, 12};
    vecs[1] = '{5, 5, 5, 5, 5, 5, 1'b0, 3};
    vecs[2] = '{398, 0, 410, 0, 398, 1, 1'b0, 6};
    vecs[3] = '{0, 0, 3, 0, 0, 3, 1'b1, 12};
    ox = '{0, 3, 0};
    oy = '{0, 0, 3};

    repeat (3) @(posedge clk);
    #1;
    reset = 1;
    check_output("reset_fb_we", fb_we, 0);
    check_output("reset_tri_count", tri_count, 0);
    check_output("reset_overflow", overflow, 0);
    check_output("reset_busy", busy, 0);
    check_output("fb_data", fb_data, 255);

    for (int i = 0; i < 4; i++) begin
      toggle_mode = vecs[i].toggle;
      if (!vecs[i].toggle) fb_ready = 1;
      write_cnt = 0;
      model_triangle(vecs[i].x0, vecs[i].y0, vecs[i].x1, vecs[i].y1, vecs[i].x2, vecs[i].y2);
      apply_stimulus(vecs[i].x0, vecs[i].y0);
      apply_stimulus(vecs[i].x1, vecs[i].y1);
      apply_stimulus(vecs[i].x2, vecs[i].y2);
      wait_done(exp_tri + 1);
      exp_tri++;
      check_output($sformatf("writes_vec%0d", i), write_cnt, vecs[i].exp_writes);
      check_output($sformatf("tri_count_vec%0d", i), tri_count, exp_tri);
      check_output($sformatf("busy_vec%0d", i), busy, 0);
      check_output($sformatf("queue_left_vec%0d", i), exp_q.size(), 0);
    end

    // Latency: third vertex push to first fb_we
    toggle_mode = 0;
    fb_ready = 1;
    write_cnt = 0;
    model_triangle(0, 0, 3, 0, 0, 3);
    apply_stimulus(0, 0);
    apply_stimulus(3, 0);
    apply_stimulus(0, 3);
    lat = 0;
    while (!fb_we && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_output("first_write_latency", lat, 5);
    wait_done(exp_tri + 1);
    exp_tri++;
    check_output("latency_tri_count", tri_count, exp_tri);
    check_output("latency_writes", write_cnt, 12);

    // Overflow with the framebuffer stalled, then reset mid-draw
    fb_ready = 0;
    for (int v = 0; v < 8; v++) apply_stimulus(ox[v % 3], oy[v % 3]);
    repeat (2) @(posedge clk);
    #1;
    check_output("ovf_overflow", overflow, 1);
    check_output("ovf_busy", busy, 1);
    check_output("ovf_fb_we_stalled", fb_we, 1);
    reset = 0;
    @(posedge clk);
    #1;
    check_output("midreset_fb_we", fb_we, 0);
    check_output("midreset_busy", busy, 0);
    check_output("midreset_overflow", overflow, 0);
    check_output("midreset_tri_count", tri_count, 0);
    reset = 1;
    fb_ready = 1;
    exp_q.delete();
    write_cnt = 0;
    repeat (20) @(posedge clk);
    #1;
    check_output("post_reset_writes", write_cnt, 0);
    check_output("post_reset_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
